// File: rtl/vram_access_seq.sv
// VRAM bus sequencer: runs complete read/write cycles (turnaround, setup, strobe, hold) on the shared VRAM pins.
// Optional macro VRAM_ACCESS_AUTOINC_EN adds cmd_inc (address = previous address + 1).
module vram_access_seq #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int TURN_CYCLES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only while idle, and rsp_valid is a one-cycle pulse with no back-pressure.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_chip,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [2*DATA_W-1:0]   cmd_wdata,
`ifdef VRAM_ACCESS_AUTOINC_EN
    input  logic                  cmd_inc,
`endif
    output logic                  rsp_valid,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic                  busy,
    output logic                  vrd_n,
    output logic                  vawr_n,
    output logic                  vbwr_n,
    output logic                  va14,
    output logic [ADDR_W-2:0]     vaa,
    output logic [ADDR_W-2:0]     vab,
    output logic                  lvl_vd_dir,
    output logic                  vd_tristate,
    output logic [DATA_W-1:0]     vda_o,
    output logic [DATA_W-1:0]     vdb_o,
    input  logic [DATA_W-1:0]     vda_i,
    input  logic [DATA_W-1:0]     vdb_i,
    output logic [2:0]            dbg_state_o
);

    localparam int MAX_SA  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_HT  = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int MAX_CYC = (MAX_SA > MAX_HT) ? MAX_SA : MAX_HT;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TURN   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q;
    logic [1:0]          chip_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   vda_q, vdb_q;
    logic                dir_q, tri_q;
    logic                vrd_n_q, vawr_n_q, vbwr_n_q;
    logic [2*DATA_W-1:0] sample_q, rdata_q;
    logic                rsp_valid_q;
    logic                accept, cnt_zero;
    logic [ADDR_W-1:0]   addr_sel;

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign cnt_zero = (cnt_q == '0);

`ifdef VRAM_ACCESS_AUTOINC_EN
    // addr_q holds the previous address, so it doubles as the increment base (wraps naturally).
    assign addr_sel = cmd_inc ? (addr_q + ADDR_W'(1)) : cmd_addr;
`else
    assign addr_sel = cmd_addr;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // A read only needs a turnaround when the FPGA is still driving the data bus.
                    if (!cmd_write && dir_q) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            chip_q      <= 2'b00;
            addr_q      <= '0;
            vda_q       <= '0;
            vdb_q       <= '0;
            dir_q       <= 1'b0;
            tri_q       <= 1'b1;
            vrd_n_q     <= 1'b1;
            vawr_n_q    <= 1'b1;
            vbwr_n_q    <= 1'b1;
            sample_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                write_q <= cmd_write;
                chip_q  <= cmd_chip;
                addr_q  <= addr_sel;
                if (cmd_write) begin
                    dir_q <= 1'b1;
                    tri_q <= 1'b0;
                    vda_q <= cmd_wdata[DATA_W-1:0];
                    vdb_q <= cmd_wdata[2*DATA_W-1:DATA_W];
                end else begin
                    dir_q <= 1'b0;
                    tri_q <= 1'b1;
                end
            end
            // Strobes are registered from the next state so they are low exactly while in STROBE.
            vrd_n_q  <= !((state_d == ST_STROBE) && !write_q);
            vawr_n_q <= !((state_d == ST_STROBE) && write_q && chip_q[0]);
            vbwr_n_q <= !((state_d == ST_STROBE) && write_q && chip_q[1]);
            if ((state_q == ST_STROBE) && cnt_zero && !write_q) begin
                sample_q <= {vdb_i, vda_i};
            end
            if ((state_q == ST_HOLD) && cnt_zero && !write_q) begin
                rsp_valid_q <= 1'b1;
                rdata_q     <= sample_q;
            end
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign vrd_n       = vrd_n_q;
    assign vawr_n      = vawr_n_q;
    assign vbwr_n      = vbwr_n_q;
    assign va14        = addr_q[ADDR_W-1];
    assign vaa         = addr_q[ADDR_W-2:0];
    assign vab         = addr_q[ADDR_W-2:0];
    assign lvl_vd_dir  = dir_q;
    assign vd_tristate = tri_q;
    assign vda_o       = vda_q;
    assign vdb_o       = vdb_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vram_access_seq.sv
// Bench for vram_access_seq: a VRAM pad model behind the pins, a vector table, hand-written
// corner sequences and random commands checked against a command-level reference model.
module tb_vram_access_seq;

    localparam int S  = 2;
    localparam int T  = 4;
    localparam int H  = 2;
    localparam int TU = 2;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_chip;
    logic [14:0] cmd_addr;
    logic [15:0] cmd_wdata;
`ifdef VRAM_ACCESS_AUTOINC_EN
    logic        cmd_inc;
`endif
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        vrd_n, vawr_n, vbwr_n;
    logic        va14;
    logic [13:0] vaa, vab;
    logic        lvl_vd_dir, vd_tristate;
    logic [7:0]  vda_o, vdb_o, vda_i, vdb_i;
    logic [2:0]  dbg_state;

    vram_access_seq dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_chip(cmd_chip), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef VRAM_ACCESS_AUTOINC_EN
        .cmd_inc(cmd_inc),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n),
        .va14(va14), .vaa(vaa), .vab(vab),
        .lvl_vd_dir(lvl_vd_dir), .vd_tristate(vd_tristate),
        .vda_o(vda_o), .vdb_o(vdb_o), .vda_i(vda_i), .vdb_i(vdb_i),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- VRAM pad model ----------------
    logic [7:0] pad_a [0:32767];
    logic [7:0] pad_b [0:32767];
    logic       pads_live;

    // Read data is only meaningful while the read strobe is low.
    assign vda_i = vrd_n ? 8'hEE : pad_a[{va14, vaa}];
    assign vdb_i = vrd_n ? 8'hEE : pad_b[{va14, vab}];

    always @(negedge clock) begin
        if (pads_live && lvl_vd_dir && !vd_tristate) begin
            if (!vawr_n) pad_a[{va14, vaa}] = vda_o;
            if (!vbwr_n) pad_b[{va14, vab}] = vdb_o;
        end
    end

    function automatic logic [7:0] init_a(input logic [14:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] init_b(input logic [14:0] a);
        return a[14:7] ^ 8'h3C;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  ref_a [0:32767];
    logic [7:0]  ref_b [0:32767];
    logic        ref_driven;
    logic [14:0] ref_prev;
    logic [15:0] ref_last;

    typedef struct {
        int busy; int wa; int wb; int rd; int first; int rsp; int rdata; int addr;
        int overlap; int bad_addr; int bad_data; int bad_bus; int bad_ready;
    } obs_t;

    function automatic obs_t predict(input logic wr, input logic [1:0] chip,
                                     input logic [14:0] addr, input logic inc);
        obs_t e;
        logic [14:0] ea;
        int turn;
        e = '{default: 0};
        ea = inc ? ref_prev + 15'd1 : addr;
        turn = (!wr && ref_driven) ? TU : 0;
        e.busy  = S + T + H + turn;
        e.wa    = (wr && chip[0]) ? T : 0;
        e.wb    = (wr && chip[1]) ? T : 0;
        e.rd    = wr ? 0 : T;
        e.first = (wr && chip == 2'b00) ? -1 : S + turn;
        e.rsp   = wr ? 0 : 1;
        e.rdata = wr ? int'(ref_last) : int'({ref_b[ea], ref_a[ea]});
        e.addr  = int'(ea);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t o, input obs_t e);
        check({tag, " busy_cycles"}, o.busy, e.busy);
        check({tag, " wa_low"}, o.wa, e.wa);
        check({tag, " wb_low"}, o.wb, e.wb);
        check({tag, " rd_low"}, o.rd, e.rd);
        check({tag, " first_strobe"}, o.first, e.first);
        check({tag, " rsp_pulses"}, o.rsp, e.rsp);
        check({tag, " rdata"}, o.rdata, e.rdata);
        check({tag, " addr"}, o.addr, e.addr);
        check({tag, " strobe_overlap"}, o.overlap, 0);
        check({tag, " addr_stable"}, o.bad_addr, 0);
        check({tag, " wdata_on_strobe"}, o.bad_data, 0);
        check({tag, " bus_direction"}, o.bad_bus, 0);
        check({tag, " ready_while_busy"}, o.bad_ready, 0);
    endtask

    // ---------------- driver ----------------
    task automatic exec(input logic wr, input logic [1:0] chip, input logic [14:0] addr,
                        input logic [15:0] wdata, input logic inc, output obs_t o);
        logic [14:0] ea;
        logic done;
        ea = inc ? ref_prev + 15'd1 : addr;
        o = '{default: 0};
        o.first = -1;
        done = 1'b0;
        @(negedge clock);
        check("ready_when_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_chip  = chip;
        cmd_addr  = addr;
        cmd_wdata = wdata;
`ifdef VRAM_ACCESS_AUTOINC_EN
        cmd_inc   = inc;
`endif
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (rsp_valid) o.rsp++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (c == 0) o.addr = int'({va14, vaa});
            o.busy++;
            if (!vawr_n) o.wa++;
            if (!vbwr_n) o.wb++;
            if (!vrd_n) o.rd++;
            if (o.first < 0 && (!vawr_n || !vbwr_n || !vrd_n)) o.first = c;
            if (!vrd_n && (!vawr_n || !vbwr_n)) o.overlap++;
            if ({va14, vaa} != ea || vab != vaa) o.bad_addr++;
            if ((!vawr_n || !vbwr_n) && (vda_o != wdata[7:0] || vdb_o != wdata[15:8])) o.bad_data++;
            if (wr ? (!lvl_vd_dir || vd_tristate) : (lvl_vd_dir || !vd_tristate)) o.bad_bus++;
            if (cmd_ready) o.bad_ready++;
        end
        check("cycle_completes", int'(done), 1);
        @(negedge clock);
        if (rsp_valid) o.rsp++;
        o.rdata = int'(rsp_rdata);
        ref_prev = ea;
        if (wr) begin
            if (chip[0]) ref_a[ea] = wdata[7:0];
            if (chip[1]) ref_b[ea] = wdata[15:8];
            ref_driven = 1'b1;
        end else begin
            ref_last   = {ref_b[ea], ref_a[ea]};
            ref_driven = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ref_prev   = '0;
        ref_driven = 1'b0;
        ref_last   = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic wr; logic [1:0] chip; logic [14:0] addr; logic [15:0] wdata;
        int busy; int wa; int wb; int rd; int first; int rsp; int rdata;
    } vec_t;

    vec_t        vecs [10];
    logic [14:0] pool [8];

    initial begin
        obs_t o, e;
        logic wr;
        logic [1:0] chip;
        logic [14:0] addr;
        logic [15:0] wdata;

        vecs[0] = '{1'b1, 2'b11, 15'h4123, 16'hB2A1,  8, 4, 4, 0,  2, 0, 'h0000};
        vecs[1] = '{1'b1, 2'b01, 15'h0456, 16'h1122,  8, 4, 0, 0,  2, 0, 'h0000};
        vecs[2] = '{1'b1, 2'b00, 15'h0010, 16'h3344,  8, 0, 0, 0, -1, 0, 'h0000};
        vecs[3] = '{1'b1, 2'b11, 15'h2000, 16'hC35A,  8, 4, 4, 0,  2, 0, 'h0000};
        vecs[4] = '{1'b0, 2'b00, 15'h2000, 16'h0000, 10, 0, 0, 4,  4, 1, 'hC35A};
        vecs[5] = '{1'b0, 2'b11, 15'h4123, 16'h0000,  8, 0, 0, 4,  2, 1, 'hB2A1};
        vecs[6] = '{1'b0, 2'b00, 15'h0456, 16'h0000,  8, 0, 0, 4,  2, 1, 'h3422};
        vecs[7] = '{1'b0, 2'b00, 15'h0010, 16'h0000,  8, 0, 0, 4,  2, 1, 'h3C4A};
        vecs[8] = '{1'b1, 2'b10, 15'h7FFF, 16'h9988,  8, 0, 4, 0,  2, 0, 'h3C4A};
        vecs[9] = '{1'b0, 2'b00, 15'h7FFF, 16'h0000, 10, 0, 0, 4,  4, 1, 'h99A5};
        pool = '{15'h4123, 15'h0456, 15'h0010, 15'h2000, 15'h7FFF, 15'h0300, 15'h0000, 15'h1555};

        for (int i = 0; i < 32768; i++) begin
            pad_a[i] = init_a(15'(i));
            pad_b[i] = init_b(15'(i));
            ref_a[i] = init_a(15'(i));
            ref_b[i] = init_b(15'(i));
        end
        pads_live  = 1'b0;
        ref_driven = 1'b0;
        ref_prev   = '0;
        ref_last   = '0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_chip   = 2'b00;
        cmd_addr   = '0;
        cmd_wdata  = '0;
`ifdef VRAM_ACCESS_AUTOINC_EN
        cmd_inc    = 1'b0;
`endif

        // Reset state after three cycles of reset.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset vrd_n", int'(vrd_n), 1);
        check("reset vawr_n", int'(vawr_n), 1);
        check("reset vbwr_n", int'(vbwr_n), 1);
        check("reset vd_tristate", int'(vd_tristate), 1);
        check("reset lvl_vd_dir", int'(lvl_vd_dir), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_rdata", int'(rsp_rdata), 0);
        check("reset address", int'({va14, vaa, vab}), 0);
        check("reset data_out", int'({vdb_o, vda_o}), 0);
        reset = 1'b1;
        pads_live = 1'b1;

        for (int i = 0; i < 10; i++) begin
            exec(vecs[i].wr, vecs[i].chip, vecs[i].addr, vecs[i].wdata, 1'b0, o);
            e = '{default: 0};
            e.busy = vecs[i].busy; e.wa = vecs[i].wa; e.wb = vecs[i].wb; e.rd = vecs[i].rd;
            e.first = vecs[i].first; e.rsp = vecs[i].rsp; e.rdata = vecs[i].rdata;
            e.addr = int'(vecs[i].addr);
            compare_obs($sformatf("vec%0d", i), o, e);
        end

        // Back-pressure during STROBE, then reset in the middle of the strobe.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_chip = 2'b11;
        cmd_addr = 15'h0300; cmd_wdata = 16'h7766;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("bp strobe_low", int'(vawr_n), 0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 15'h1555;
        check("bp cmd_ready", int'(cmd_ready), 0);
        @(negedge clock);
        check("bp write_continues", int'(vawr_n), 0);
        check("bp read_not_taken", int'(vrd_n), 1);
        reset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
        check("rst strobes_high", int'({vrd_n, vawr_n, vbwr_n}), 7);
        check("rst bus_released", int'({lvl_vd_dir, vd_tristate}), 1);
        check("rst busy", int'(busy), 0);
        check("rst rsp_valid", int'(rsp_valid), 0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("post_rst%0d busy_rsp", k), int'({busy, rsp_valid}), 0);
        end
        ref_a[15'h0300] = 8'h66;
        ref_b[15'h0300] = 8'h77;
        ref_driven = 1'b0;
        ref_prev   = '0;
        ref_last   = '0;

        // Random commands against the reference model.
        for (int n = 0; n < 150; n++) begin
            wr    = 1'($urandom_range(0, 1));
            chip  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : pool[$urandom_range(0, 7)];
            wdata = 16'($urandom);
            e = predict(wr, chip, addr, 1'b0);
            exec(wr, chip, addr, wdata, 1'b0, o);
            compare_obs($sformatf("rnd%0d", n), o, e);
        end

`ifdef VRAM_ACCESS_AUTOINC_EN
        // Increment wraps 0x7FFF to 0x0000; after reset the first increment uses address 1.
        e = predict(1'b1, 2'b11, 15'h7FFF, 1'b0);
        exec(1'b1, 2'b11, 15'h7FFF, 16'h2468, 1'b0, o);
        compare_obs("inc_base", o, e);
        e = predict(1'b1, 2'b11, 15'h1234, 1'b1);
        exec(1'b1, 2'b11, 15'h1234, 16'h1357, 1'b1, o);
        compare_obs("inc_wrap", o, e);
        check("inc_wrap pins", o.addr, 0);
        pulse_reset();
        e = predict(1'b1, 2'b01, 15'h4444, 1'b1);
        exec(1'b1, 2'b01, 15'h4444, 16'h00AB, 1'b1, o);
        compare_obs("inc_after_reset", o, e);
        check("inc_after_reset pins", o.addr, 1);
`else
        pulse_reset();
        e = predict(1'b0, 2'b00, 15'h0300, 1'b0);
        exec(1'b0, 2'b00, 15'h0300, 16'h0000, 1'b0, o);
        compare_obs("read_after_reset", o, e);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_access_seq.md
Name: vram_access_seq

Overview:
- Parametrised VRAM bus sequencer. It replaces manual single-stepping of the VRAM pins with complete read and write cycles whose timing is set by parameters.
- Accepts one command at a time over a valid/ready interface, typically from a UART command decoder.
- Drives the shared VRAM address bus, the per-chip write strobes, the shared read strobe and the data-bus direction/tristate. Returns read data for both chips.
- Owns the VRAM pins while the SNES PPUs are held in reset.

Parameters:
- ADDR_W, 15: full VRAM address width. Bit ADDR_W-1 drives va14; bits ADDR_W-2:0 drive vaa and vab.
- DATA_W, 8: data width per chip.
- SETUP_CYCLES, 2: cycles address/data are stable before the strobe. Must be ≥1.
- STROBE_CYCLES, 4: cycles a strobe is held low. Must be ≥1.
- HOLD_CYCLES, 2: cycles address/data are held after the strobe rises. Must be ≥1.
- TURN_CYCLES, 2: bus-turnaround cycles when switching from driving to receiving. Must be ≥1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_chip  in  2  write enable mask; bit0 = chip A, bit1 = chip B. Ignored for reads.
- cmd_addr  in  ADDR_W  VRAM address.
- cmd_wdata  in  2*DATA_W  write data, {B, A}.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_rdata  out  2*DATA_W  read data, {vdb_i, vda_i}.
- busy  out  1  cycle in progress.
- vrd_n, vawr_n, vbwr_n  out  1 each  VRAM strobes, active-low.
- va14  out  1;  vaa, vab  out  ADDR_W-1  address pins.
- lvl_vd_dir  out  1  level-shifter direction; 1 = FPGA drives.
- vd_tristate  out  1  1 = FPGA data pads released.
- vda_o, vdb_o  out  DATA_W  data to pads.
- vda_i, vdb_i  in  DATA_W  data from pads.

Behaviour:
- Reset values: strobes 1; address 0; lvl_vd_dir 0; vd_tristate 1; vda_o = vdb_o = 0; cmd_ready 1; busy 0; rsp_valid 0; rsp_rdata 0.
- Reset is synchronous and overrides everything, including a cycle already in progress. On the next edge all strobes go high and the bus is released.
- States: IDLE, TURN, SETUP, STROBE, HOLD.
- cmd_ready = 1 only in IDLE. A command is accepted on a clock edge where cmd_valid & cmd_ready. Address, data, mask and direction are latched at acceptance.
- Outputs are registered. Pins change on the edge after acceptance.
- Write sequence: IDLE → SETUP.
  - SETUP: address driven; lvl_vd_dir = 1; vd_tristate = 0; data driven; lasts SETUP_CYCLES.
  - STROBE: vawr_n = ~cmd_chip[0], vbwr_n = ~cmd_chip[1]; lasts STROBE_CYCLES.
  - HOLD: strobes high, data still driven; lasts HOLD_CYCLES.
  - Then IDLE. The bus stays driven after a write (direction is sticky).
- cmd_chip = 0 on a write: full timing runs, no strobe falls.
- Read sequence:
  - If the bus is driven at acceptance: TURN first. lvl_vd_dir = 0 and vd_tristate = 1 for TURN_CYCLES; address is already driven.
  - Otherwise go straight to SETUP.
  - SETUP (SETUP_CYCLES) → STROBE: vrd_n = 0 for STROBE_CYCLES. {vdb_i, vda_i} is sampled on the last STROBE cycle.
  - HOLD: vrd_n high for HOLD_CYCLES.
  - On the final HOLD edge, return to IDLE and pulse rsp_valid for one cycle with the sampled data. rsp_rdata holds its value until the next read.
- Write after read: the data bus is re-enabled in the first SETUP cycle. No turnaround is needed, because the read strobe is already high.
- vrd_n and a write strobe are never low in the same cycle.
- Write data is driven in every cycle in which a write strobe is low.
- Latency from acceptance to returning to IDLE:
  - write: S+T+H cycles;
  - read: S+T+H cycles, plus TURN_CYCLES if a turnaround was needed.
  - (S = SETUP_CYCLES, T = STROBE_CYCLES, H = HOLD_CYCLES.)
- One down-counter handles all phase durations. Its width is $clog2 of the largest parameter + 1.

Optional Feature:
- Macro VRAM_ACCESS_AUTOINC_EN. When defined, the block adds input cmd_inc (1 bit).
  - If cmd_inc = 1 at acceptance, cmd_addr is ignored and the address used is the previous address + 1, modulo 2^ADDR_W (0x7FFF wraps to 0x0000).
  - After reset the previous address is 0, so the first increment uses address 1.
- When not defined, there is no cmd_inc port and every command uses cmd_addr.

Test Plan:
- Reset check: hold reset = 0 for 3 cycles → vrd_n = vawr_n = vbwr_n = 1, vd_tristate = 1, lvl_vd_dir = 0, cmd_ready = 1.
- Single write: addr 0x4123, wdata 0xB2A1, chip 2'b11, defaults → va14 = 1, vaa = vab = 0x0123; vda_o = 0xA1, vdb_o = 0xB2; vawr_n and vbwr_n low for exactly 4 cycles, 2 cycles after the first pin change; busy for 8 cycles.
- Masked write: chip 2'b01 → only vawr_n pulses; vbwr_n stays 1. Chip 2'b00 → no strobe falls; still 8 busy cycles.
- Read after write: model returns A = 0x5A, B = 0xC3 → 2 turnaround cycles with vd_tristate = 1 before SETUP; vrd_n low for 4 cycles; rsp_valid pulses once with rsp_rdata = 0xC35A; no cycle has vrd_n and a write strobe low together.
- Back-pressure plus reset: assert cmd_valid during STROBE → cmd_ready = 0 and the command is not taken. Then pull reset low mid-STROBE → next edge all strobes high, bus released, no rsp_valid.
- With VRAM_ACCESS_AUTOINC_EN: write to 0x7FFF, then an inc write → second access drives address 0x0000.
